// File: rtl/datamover_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Package  : datamover_fsm_pkg
// Brief    : Job, state and streamer control/flag types for the datamover FSM.
// Revision : 1.0 - initial release
// ============================================================================
package datamover_fsm_pkg;

  localparam int DATAMOVER_CNT_W                 = 32;
  localparam int DATAMOVER_START_TIMEOUT_DEFAULT = 0;

  typedef struct packed {
    logic [DATAMOVER_CNT_W-1:0] in_ptr;
    logic [DATAMOVER_CNT_W-1:0] out_ptr;
    logic [DATAMOVER_CNT_W-1:0] tot_len;
    logic [DATAMOVER_CNT_W-1:0] in_d0_len;
    logic [DATAMOVER_CNT_W-1:0] in_d0_stride;
    logic [DATAMOVER_CNT_W-1:0] in_d1_len;
    logic [DATAMOVER_CNT_W-1:0] in_d1_stride;
    logic [DATAMOVER_CNT_W-1:0] in_d2_stride;
    logic [DATAMOVER_CNT_W-1:0] out_d0_len;
    logic [DATAMOVER_CNT_W-1:0] out_d0_stride;
    logic [DATAMOVER_CNT_W-1:0] out_d1_len;
    logic [DATAMOVER_CNT_W-1:0] out_d1_stride;
    logic [DATAMOVER_CNT_W-1:0] out_d2_stride;
  } datamover_job_t;

  typedef enum logic [2:0] {
    DM_IDLE  = 3'd0,
    DM_START = 3'd1,
    DM_RUN   = 3'd2,
    DM_DRAIN = 3'd3,
    DM_DONE  = 3'd4
  } datamover_state_t;

  typedef struct packed {
    logic [31:0] base_addr;
    logic [31:0] tot_len;
    logic [31:0] d0_len;
    logic [31:0] d0_stride;
    logic [31:0] d1_len;
    logic [31:0] d1_stride;
    logic [31:0] d2_stride;
    logic [1:0]  dim_enable_1h;
  } addressgen_ctrl_t;

  typedef struct packed {
    logic             req_start;
    addressgen_ctrl_t addressgen_ctrl;
  } streamer_ctrl_t;

  typedef struct packed {
    streamer_ctrl_t data_in_source_ctrl;
    streamer_ctrl_t data_out_sink_ctrl;
  } ctrl_streamer_t;

  typedef struct packed {
    logic ready_start;
  } streamer_flags_t;

  typedef struct packed {
    streamer_flags_t data_in_source_flags;
    streamer_flags_t data_out_sink_flags;
    logic            tcdm_fifo_empty;
  } flags_streamer_t;

  function automatic addressgen_ctrl_t dm_addressgen(
    input logic [31:0] base_addr, tot_len, d0_len, d0_stride,
    input logic [31:0] d1_len, d1_stride, d2_stride
  );
    addressgen_ctrl_t a;
    a.base_addr     = base_addr;
    a.tot_len       = tot_len;
    a.d0_len        = d0_len;
    a.d0_stride     = d0_stride;
    a.d1_len        = d1_len;
    a.d1_stride     = d1_stride;
    a.d2_stride     = d2_stride;
    a.dim_enable_1h = 2'b11;
    return a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/datamover_fsm_beat_counter.sv
`default_nettype none
// ============================================================================
// Module   : datamover_beat_counter
// Brief    : Saturating beat counter with clear, enable and terminal compare.
// Revision : 1.0 - initial release
// ============================================================================
module datamover_beat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != i_limit)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  // Next accepted beat is the final one of the job.
  assign o_last = (r_cnt == (i_limit - 1'b1));

endmodule
`default_nettype wire

// File: rtl/datamover_fsm.sv
`default_nettype none
// ============================================================================
// Module   : datamover_fsm
// Brief    : Job sequencer starting the source/sink streamers and counting beats.
// Revision : 1.0 - initial release
// ============================================================================
module datamover_fsm
  import datamover_fsm_pkg::*;
#(
  parameter int CNT_W         = DATAMOVER_CNT_W,
  parameter int START_TIMEOUT = DATAMOVER_START_TIMEOUT_DEFAULT
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             start_i,
  input  datamover_job_t   job_i,
  input  flags_streamer_t  flags_streamer_i,
  input  logic             out_beat_i,
  output ctrl_streamer_t   ctrl_streamer_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [CNT_W-1:0] beat_cnt_o
);

  localparam logic [2:0] c_st_idle  = DM_IDLE;
  localparam logic [2:0] c_st_start = DM_START;
  localparam logic [2:0] c_st_run   = DM_RUN;
  localparam logic [2:0] c_st_drain = DM_DRAIN;
  localparam logic [2:0] c_st_done  = DM_DONE;

  localparam int c_wait_w = (START_TIMEOUT > 1) ? $clog2(START_TIMEOUT) : 1;
  localparam logic [c_wait_w-1:0] c_wait_last =
    c_wait_w'((START_TIMEOUT > 0) ? (START_TIMEOUT - 1) : 0);

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  datamover_job_t      r_job;
  logic                r_done;
  logic                r_err;
  logic [c_wait_w-1:0] r_wait;
  logic [CNT_W-1:0]    w_tot_len;
  logic                w_cnt_last;
  logic                w_accept;
  logic                w_zero_len;
  logic                w_both_ready;
  logic                w_req_start;
  logic                w_timeout;
  logic                w_drained;
  logic                w_cnt_en;

  assign w_tot_len    = CNT_W'(r_job.tot_len);
  assign w_zero_len   = (CNT_W'(job_i.tot_len) == '0);
  assign w_accept     = (r_state == c_st_idle) && start_i && !clear_i;
  assign w_both_ready = flags_streamer_i.data_in_source_flags.ready_start &&
                        flags_streamer_i.data_out_sink_flags.ready_start;
  assign w_req_start  = (r_state == c_st_start) && w_both_ready && !clear_i;
  assign w_timeout    = (START_TIMEOUT > 0) && (r_state == c_st_start) &&
                        !w_both_ready && (r_wait == c_wait_last);
  // All stores retired: TCDM FIFO empty and the sink back to ready.
  assign w_drained    = flags_streamer_i.tcdm_fifo_empty &&
                        flags_streamer_i.data_out_sink_flags.ready_start;
  assign w_cnt_en     = out_beat_i && ((r_state == c_st_run) || (r_state == c_st_drain));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (start_i) w_state_nxt = w_zero_len ? c_st_done : c_st_start;
      c_st_start: begin
        if (w_both_ready)   w_state_nxt = c_st_run;
        else if (w_timeout) w_state_nxt = c_st_done;
      end
      c_st_run:   if (out_beat_i && w_cnt_last) w_state_nxt = c_st_drain;
      c_st_drain: if (w_drained) w_state_nxt = c_st_done;
      c_st_done:  w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
    if (clear_i) w_state_nxt = c_st_idle;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= c_st_idle;
      r_job   <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_wait  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= (r_state == c_st_done) && !clear_i;
      r_wait  <= ((r_state == c_st_start) && !clear_i) ? r_wait + 1'b1 : '0;
      if (clear_i) begin
        r_job <= '0;
        r_err <= 1'b0;
      end else begin
        if (w_accept)  r_job <= job_i;
        if (w_timeout) r_err <= 1'b1;
      end
    end
  end

  datamover_beat_counter #(
    .CNT_W (CNT_W)
  ) u_beat_counter (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .i_clear (clear_i || w_accept),
    .i_en    (w_cnt_en),
    .i_limit (w_tot_len),
    .o_cnt   (beat_cnt_o),
    .o_last  (w_cnt_last)
  );

  // Address-generator fields follow the latched job for the whole job lifetime.
  always_comb begin
    ctrl_streamer_o = '0;
    if (r_state != c_st_idle) begin
      ctrl_streamer_o.data_in_source_ctrl.addressgen_ctrl = dm_addressgen(
        r_job.in_ptr, r_job.tot_len, r_job.in_d0_len, r_job.in_d0_stride,
        r_job.in_d1_len, r_job.in_d1_stride, r_job.in_d2_stride);
      ctrl_streamer_o.data_out_sink_ctrl.addressgen_ctrl = dm_addressgen(
        r_job.out_ptr, r_job.tot_len, r_job.out_d0_len, r_job.out_d0_stride,
        r_job.out_d1_len, r_job.out_d1_stride, r_job.out_d2_stride);
    end
    ctrl_streamer_o.data_in_source_ctrl.req_start = w_req_start;
    ctrl_streamer_o.data_out_sink_ctrl.req_start  = w_req_start;
  end

  assign busy_o = (r_state != c_st_idle) || r_done;
  assign done_o = r_done;
  assign err_o  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_datamover_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_datamover_fsm
// Brief    : Randomized self-checking bench for datamover_fsm.
// Revision : 1.0 - initial release
// ============================================================================
module tb_datamover_fsm;
  import datamover_fsm_pkg::*;

  localparam int CNT_W = 32;
  localparam int MAXC  = 200;

  logic            clk = 1'b0;
  logic            rst_ni, clear_i, start_i, out_beat_i;
  datamover_job_t  job_i;
  flags_streamer_t flags_i;
  ctrl_streamer_t  ctrl_o, ctrl_t;
  logic            busy_o, done_o, err_o, busy_t, done_t, err_t;
  logic [CNT_W-1:0] cnt_o, cnt_t;
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  datamover_fsm #(.CNT_W(CNT_W), .START_TIMEOUT(0)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .job_i(job_i), .flags_streamer_i(flags_i), .out_beat_i(out_beat_i),
    .ctrl_streamer_o(ctrl_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .beat_cnt_o(cnt_o));

  datamover_fsm #(.CNT_W(CNT_W), .START_TIMEOUT(3)) dut_to (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .job_i(job_i), .flags_streamer_i(flags_i), .out_beat_i(out_beat_i),
    .ctrl_streamer_o(ctrl_t), .busy_o(busy_t), .done_o(done_t), .err_o(err_t),
    .beat_cnt_o(cnt_t));

  task automatic set_in(input bit st, input bit rs, input bit rk, input bit bt, input bit em);
    start_i    = st;
    out_beat_i = bt;
    flags_i.data_in_source_flags.ready_start = rs;
    flags_i.data_out_sink_flags.ready_start  = rk;
    flags_i.tcdm_fifo_empty = em;
  endtask

  function automatic datamover_job_t mk_job(input logic [31:0] tot, input logic [31:0] ip,
                                             input logic [31:0] op);
    datamover_job_t j;
    j = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
         $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    j.tot_len = tot;
    j.in_ptr  = ip;
    j.out_ptr = op;
    return j;
  endfunction

  task automatic pulse_clear();
    set_in(0, 1, 1, 0, 1);
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    @(posedge clk); #1;
  endtask

  // Stimulus is generated up front; expected event cycles come from the job rules.
  // mode 0: random, 1: all ready, 2: fifo busy 4 cycles after last beat, 3: sink stall
  task automatic run_job(input string name, input logic [31:0] tot, input logic [31:0] ip,
                         input logic [31:0] op, input int mode);
    bit rs[MAXC], rk[MAXC], bt[MAXC], em[MAXC], sp[MAXC];
    int t_req, t_last, t_exit, t_done, nb, p_rdy, p_bt, p_em, e_cnt;
    datamover_job_t   job;
    addressgen_ctrl_t e_src, e_snk;
    logic [4:0]       obs, e_vec;
    p_rdy = $urandom_range(30, 90);
    p_bt  = $urandom_range(30, 90);
    p_em  = $urandom_range(30, 90);
    for (int c = 0; c < MAXC; c++) begin
      if (mode == 0 && c < 120) begin
        rs[c] = ($urandom_range(99) < p_rdy);
        rk[c] = ($urandom_range(99) < p_rdy);
        bt[c] = ($urandom_range(99) < p_bt);
        em[c] = ($urandom_range(99) < p_em);
      end else begin
        rs[c] = 1; rk[c] = 1; bt[c] = 1; em[c] = 1;
      end
      sp[c] = ($urandom_range(99) < 20);
    end
    if (mode == 3) for (int c = 1; c <= 5; c++) rk[c] = 0;
    job   = mk_job(tot, ip, op);
    e_src = '{base_addr: job.in_ptr, tot_len: job.tot_len, d0_len: job.in_d0_len,
              d0_stride: job.in_d0_stride, d1_len: job.in_d1_len, d1_stride: job.in_d1_stride,
              d2_stride: job.in_d2_stride, dim_enable_1h: 2'b11};
    e_snk = '{base_addr: job.out_ptr, tot_len: job.tot_len, d0_len: job.out_d0_len,
              d0_stride: job.out_d0_stride, d1_len: job.out_d1_len, d1_stride: job.out_d1_stride,
              d2_stride: job.out_d2_stride, dim_enable_1h: 2'b11};
    t_req = -1; t_last = -1; t_exit = -1; t_done = -1;
    if (tot == 0) begin
      t_done = 2;
    end else begin
      for (int c = 1; c < MAXC; c++) if (rs[c] && rk[c]) begin t_req = c; break; end
      nb = 0;
      if (t_req >= 0)
        for (int c = t_req + 1; c < MAXC; c++)
          if (bt[c]) begin nb++; if (nb == tot) begin t_last = c; break; end end
      if (mode == 2 && t_last >= 0)
        for (int c = t_last + 1; c <= t_last + 4 && c < MAXC; c++) em[c] = 0;
      if (t_last >= 0)
        for (int c = t_last + 1; c < MAXC; c++) if (em[c] && rk[c]) begin t_exit = c; break; end
      if (t_exit >= 0) t_done = t_exit + 2;
    end
    if (t_done < 0 || t_done + 3 >= MAXC) begin
      n_vec++; n_err++;
      $display("FAIL %s horizon: t_done=%0d required < %0d", name, t_done, MAXC - 3);
      return;
    end
    job_i = job;
    for (int c = 0; c <= t_done + 3; c++) begin
      set_in((c == 0) || (c < t_done && sp[c]), rs[c], rk[c], bt[c], em[c]);
      @(negedge clk);
      e_cnt = 0;
      if (tot != 0 && t_req >= 0) begin
        for (int j = t_req + 1; j < c; j++) if (bt[j]) e_cnt++;
        if (e_cnt > int'(tot)) e_cnt = int'(tot);
      end
      obs   = {ctrl_o.data_in_source_ctrl.req_start, ctrl_o.data_out_sink_ctrl.req_start,
               done_o, busy_o, err_o};
      e_vec = {c == t_req, c == t_req, c == t_done, (c >= 1) && (c <= t_done), 1'b0};
      n_vec++;
      if (obs !== e_vec) begin
        n_err++;
        $display("FAIL %s ctl c=%0d {reqs,reqk,done,busy,err} got=%b want=%b", name, c, obs, e_vec);
      end
      if (c >= 1) begin
        n_vec++;
        if (cnt_o !== 32'(e_cnt)) begin
          n_err++;
          $display("FAIL %s beat_cnt c=%0d got=%0d want=%0d", name, c, cnt_o, e_cnt);
        end
      end
      if (c == t_req) begin
        n_vec++;
        if (ctrl_o.data_in_source_ctrl.addressgen_ctrl !== e_src ||
            ctrl_o.data_out_sink_ctrl.addressgen_ctrl !== e_snk) begin
          n_err++;
          $display("FAIL %s addrgen src_base=%h want=%h snk_base=%h want=%h", name,
                   ctrl_o.data_in_source_ctrl.addressgen_ctrl.base_addr, e_src.base_addr,
                   ctrl_o.data_out_sink_ctrl.addressgen_ctrl.base_addr, e_snk.base_addr);
        end
      end
      @(posedge clk); #1;
    end
    set_in(0, 1, 1, 0, 1);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; clear_i = 1'b0; job_i = '0;
    set_in(0, 1, 1, 0, 1);
    #3;
    n_vec++;
    if ({busy_o, done_o, err_o, busy_t, done_t, err_t} !== 6'b0 || cnt_o !== '0 ||
        ctrl_o !== '0 || ctrl_t !== '0) begin
      n_err++;
      $display("FAIL reset outputs busy=%b done=%b err=%b cnt=%0d want all zero",
               busy_o, done_o, err_o, cnt_o);
    end
    @(negedge clk); rst_ni = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    run_job("basic", 32'd16, 32'h1000, 32'h2000, 1);
  endtask

  task automatic test_zero_length();
    run_job("zero_len", 32'd0, 32'h3000, 32'h4000, 1);
  endtask

  task automatic test_ready_stall();
    run_job("ready_stall", 32'd8, 32'h5000, 32'h6000, 3);
  endtask

  task automatic test_drain_gating();
    run_job("drain_gate", 32'd16, 32'h7000, 32'h8000, 2);
  endtask

  task automatic test_start_timeout();
    logic [4:0] obs, e_vec;
    pulse_clear();
    job_i = mk_job(32'd16, 32'h9000, 32'hA000);
    for (int c = 0; c <= 8; c++) begin
      set_in(c == 0, 1, !(c >= 1 && c <= 5), 0, 1);
      @(negedge clk);
      obs   = {ctrl_t.data_in_source_ctrl.req_start, ctrl_t.data_out_sink_ctrl.req_start,
               done_t, busy_t, err_t};
      e_vec = {1'b0, 1'b0, c == 5, (c >= 1) && (c <= 5), c >= 4};
      n_vec++;
      if (obs !== e_vec) begin
        n_err++;
        $display("FAIL timeout c=%0d {reqs,reqk,done,busy,err} got=%b want=%b", c, obs, e_vec);
      end
      @(posedge clk); #1;
    end
    pulse_clear();
    n_vec++;
    if (err_t !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_err_clear got=%b want=0", err_t);
    end
  endtask

  task automatic test_clear_mid_run();
    job_i = mk_job(32'd16, 32'h1100, 32'h2200);
    for (int c = 0; c <= 13; c++) begin
      set_in(c == 0, 1, 1, (c >= 2 && c <= 8), 1);
      clear_i = (c == 9);
      @(negedge clk);
      if (c == 9) begin
        n_vec++;
        if (cnt_o !== 32'd7 || busy_o !== 1'b1) begin
          n_err++;
          $display("FAIL clear_pre cnt=%0d busy=%b want cnt=7 busy=1", cnt_o, busy_o);
        end
      end
      if (c >= 10) begin
        n_vec++;
        if ({ctrl_o.data_in_source_ctrl.req_start, done_o, busy_o} !== 3'b0 || cnt_o !== '0) begin
          n_err++;
          $display("FAIL clear_post c=%0d req=%b done=%b busy=%b cnt=%0d want all 0", c,
                   ctrl_o.data_in_source_ctrl.req_start, done_o, busy_o, cnt_o);
        end
      end
      @(posedge clk); #1;
    end
    clear_i = 1'b0;
    run_job("clear_rerun", 32'd16, 32'h1100, 32'h2200, 1);
  endtask

  task automatic test_max_len();
    job_i = mk_job(32'hFFFF_FFFF, 32'h0, 32'h0);
    for (int c = 0; c <= 12; c++) begin
      set_in(c == 0, 1, 1, c >= 2, 1);
      @(negedge clk);
      if (c == 12) begin
        n_vec++;
        if (cnt_o !== 32'd10 || busy_o !== 1'b1 || done_o !== 1'b0) begin
          n_err++;
          $display("FAIL max_len cnt=%0d busy=%b done=%b want cnt=10 busy=1 done=0",
                   cnt_o, busy_o, done_o);
        end
      end
      @(posedge clk); #1;
    end
    pulse_clear();
  endtask

  task automatic test_random_jobs();
    for (int k = 0; k < 8; k++)
      run_job($sformatf("rand%0d", k), (k == 3) ? 32'd0 : ((k == 5) ? 32'd1 : 32'($urandom_range(2, 20))),
              $urandom, $urandom, 0);
  endtask

  task automatic test_async_reset();
    job_i = mk_job(32'd4, 32'hBEEF, 32'hCAFE);
    for (int c = 0; c <= 7; c++) begin
      set_in(c == 0, 1, 1, (c >= 2 && c <= 5), c < 6);
      @(negedge clk);
      if (c == 7) begin
        n_vec++;
        if (busy_o !== 1'b1 || cnt_o !== 32'd4 || done_o !== 1'b0) begin
          n_err++;
          $display("FAIL drain_hold busy=%b cnt=%0d done=%b want 1,4,0", busy_o, cnt_o, done_o);
        end
      end
      if (c < 7) begin @(posedge clk); #1; end
    end
    #2 rst_ni = 1'b0;
    #1;
    n_vec++;
    if ({busy_o, done_o, err_o, busy_t, done_t} !== 5'b0 || cnt_o !== '0 || ctrl_o !== '0 ||
        ctrl_t !== '0) begin
      n_err++;
      $display("FAIL async_reset busy=%b done=%b err=%b cnt=%0d want all zero",
               busy_o, done_o, err_o, cnt_o);
    end
    @(negedge clk); rst_ni = 1'b1;
    set_in(0, 1, 1, 0, 1);
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_vec++;
      if (done_o !== 1'b0 || busy_o !== 1'b0) begin
        n_err++;
        $display("FAIL post_reset c=%0d done=%b busy=%b want 0,0", c, done_o, busy_o);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_ready_stall();
    test_start_timeout();
    test_drain_gating();
    test_clear_mid_run();
    test_max_len();
    test_random_jobs();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
